// File: rtl/datapath_dispatcher.sv
// datapath_dispatcher
// Shares UNITS identical datapath units among PORTS requesters. Each port latches
// its instruction, waits for a round-robin grant onto the lowest free unit, and
// receives that unit's result in its own slot; completions may arrive out of order.
//
// Port FSM
//   state     | meaning
//   P_IDLE    | no request outstanding, req_finished high, result slot valid
//   P_PENDING | instruction latched, waiting for a free unit
//   P_ISSUED  | instruction handed to a unit, waiting for its completion
//
// Unit FSM
//   state     | meaning
//   U_FREE    | available for a grant; dp_finished ignored
//   U_ARMED   | granted this cycle; dp_start high for exactly one cycle
//   U_BUSY    | running; dp_finished retires it back to U_FREE

module datapath_dispatcher #(
    parameter int PORTS    = 4,
    parameter int UNITS    = 2,
    parameter int INSTR_W  = 32,
    parameter int RESULT_W = 32
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [INSTR_W*PORTS-1:0]      req_instruction,
    input  logic [PORTS-1:0]              req_start,
    output logic [RESULT_W*PORTS-1:0]     req_result,
    output logic [PORTS-1:0]              req_finished,
    output logic [INSTR_W*UNITS-1:0]      dp_instruction,
    output logic [UNITS-1:0]              dp_start,
    input  logic [RESULT_W*UNITS-1:0]     dp_result,
    input  logic [UNITS-1:0]              dp_finished,
    output logic [$clog2(UNITS+1)-1:0]    active_count
);

    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int UW = (UNITS > 1) ? $clog2(UNITS) : 1;
    localparam int CW = $clog2(UNITS + 1);

    typedef enum logic [1:0] {P_IDLE, P_PENDING, P_ISSUED} port_state_t;
    typedef enum logic [1:0] {U_FREE, U_ARMED, U_BUSY} unit_state_t;

    port_state_t                r_port_state [PORTS];
    port_state_t                w_port_next  [PORTS];
    unit_state_t                r_unit_state [UNITS];
    unit_state_t                w_unit_next  [UNITS];

    logic [INSTR_W-1:0]         r_instr [PORTS];
    logic [PW-1:0]              r_owner [UNITS];
    logic [PW-1:0]              r_rr_ptr;
    logic [RESULT_W*PORTS-1:0]  r_result;
    logic [PORTS-1:0]           r_finished;
    logic [INSTR_W*UNITS-1:0]   r_dp_instr;

    logic                       w_unit_found;
    logic [UW-1:0]              w_unit_sel;
    logic                       w_port_found;
    logic [PW-1:0]              w_port_sel;
    logic                       w_grant;
    logic [INSTR_W-1:0]         w_grant_instr;
    logic [UNITS-1:0]           w_unit_done;
    logic [PORTS-1:0]           w_port_done;
    logic [CW-1:0]              w_active;

    // Grant selection: lowest free unit, first pending port starting at rr_ptr.
    always_comb begin
        w_unit_found  = 1'b0;
        w_unit_sel    = '0;
        w_port_found  = 1'b0;
        w_port_sel    = '0;
        w_grant_instr = '0;
        for (int u = UNITS - 1; u >= 0; u--) begin
            if (r_unit_state[u] == U_FREE) begin
                w_unit_found = 1'b1;
                w_unit_sel   = UW'(u);
            end
        end
        for (int i = 0; i < PORTS; i++) begin
            if (!w_port_found && r_port_state[(int'(r_rr_ptr) + i) % PORTS] == P_PENDING) begin
                w_port_found = 1'b1;
                w_port_sel   = PW'((int'(r_rr_ptr) + i) % PORTS);
            end
        end
        for (int p = 0; p < PORTS; p++) begin
            if (w_port_sel == PW'(p)) begin
                w_grant_instr = r_instr[p];
            end
        end
        w_grant = w_port_found && w_unit_found;
    end

    // Completion detection: a unit retires only from BUSY, credited to its owner.
    always_comb begin
        w_unit_done = '0;
        w_port_done = '0;
        for (int u = 0; u < UNITS; u++) begin
            w_unit_done[u] = (r_unit_state[u] == U_BUSY) && dp_finished[u];
        end
        for (int p = 0; p < PORTS; p++) begin
            for (int u = 0; u < UNITS; u++) begin
                if (w_unit_done[u] && r_owner[u] == PW'(p)) begin
                    w_port_done[p] = 1'b1;
                end
            end
        end
    end

    // Next-state logic for port and unit FSMs plus per-unit status outputs.
    always_comb begin
        w_active = '0;
        dp_start = '0;
        for (int p = 0; p < PORTS; p++) begin
            w_port_next[p] = r_port_state[p];
            case (r_port_state[p])
                P_IDLE:    if (req_start[p]) w_port_next[p] = P_PENDING;
                P_PENDING: if (w_grant && w_port_sel == PW'(p)) w_port_next[p] = P_ISSUED;
                P_ISSUED:  if (w_port_done[p]) w_port_next[p] = P_IDLE;
                default:   w_port_next[p] = P_IDLE;
            endcase
        end
        for (int u = 0; u < UNITS; u++) begin
            w_unit_next[u] = r_unit_state[u];
            case (r_unit_state[u])
                U_FREE:  if (w_grant && w_unit_sel == UW'(u)) w_unit_next[u] = U_ARMED;
                U_ARMED: w_unit_next[u] = U_BUSY;
                U_BUSY:  if (dp_finished[u]) w_unit_next[u] = U_FREE;
                default: w_unit_next[u] = U_FREE;
            endcase
            dp_start[u] = (r_unit_state[u] == U_ARMED);
            if (r_unit_state[u] != U_FREE) begin
                w_active = w_active + CW'(1);
            end
        end
    end

    // FSM state registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int p = 0; p < PORTS; p++) r_port_state[p] <= P_IDLE;
            for (int u = 0; u < UNITS; u++) r_unit_state[u] <= U_FREE;
        end else begin
            for (int p = 0; p < PORTS; p++) r_port_state[p] <= w_port_next[p];
            for (int u = 0; u < UNITS; u++) r_unit_state[u] <= w_unit_next[u];
        end
    end

    // Datapath registers: instruction latch, unit dispatch, result routing, rr pointer.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int p = 0; p < PORTS; p++) r_instr[p] <= '0;
            for (int u = 0; u < UNITS; u++) r_owner[u] <= '0;
            r_rr_ptr   <= '0;
            r_result   <= '0;
            r_finished <= '1;
            r_dp_instr <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (r_port_state[p] == P_IDLE && req_start[p]) begin
                    r_instr[p]    <= req_instruction[p*INSTR_W +: INSTR_W];
                    r_finished[p] <= 1'b0;
                end
                for (int u = 0; u < UNITS; u++) begin
                    if (w_unit_done[u] && r_owner[u] == PW'(p)) begin
                        r_result[p*RESULT_W +: RESULT_W] <= dp_result[u*RESULT_W +: RESULT_W];
                        r_finished[p] <= 1'b1;
                    end
                end
            end
            if (w_grant) begin
                for (int u = 0; u < UNITS; u++) begin
                    if (w_unit_sel == UW'(u)) begin
                        r_dp_instr[u*INSTR_W +: INSTR_W] <= w_grant_instr;
                        r_owner[u] <= w_port_sel;
                    end
                end
                r_rr_ptr <= (w_port_sel == PW'(PORTS - 1)) ? '0 : w_port_sel + 1'b1;
            end
        end
    end

    assign req_result     = r_result;
    assign req_finished   = r_finished;
    assign dp_instruction = r_dp_instr;
    assign active_count   = w_active;

endmodule

// File: tb/tb_datapath_dispatcher.sv
// Directed bench for datapath_dispatcher: a 4-port/2-unit instance for reset,
// single-op latency, contention, out-of-order completion and mid-op reset, and a
// 4-port/1-unit instance for round-robin fairness.

module tb_datapath_dispatcher;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;

    logic [127:0]  req_instruction0;
    logic [3:0]    req_start0;
    logic [127:0]  req_result0;
    logic [3:0]    req_finished0;
    logic [63:0]   dp_instruction0;
    logic [1:0]    dp_start0;
    logic [63:0]   dp_result0;
    logic [1:0]    dp_finished0;
    logic [1:0]    active_count0;

    logic [127:0]  req_instruction1;
    logic [3:0]    req_start1;
    logic [127:0]  req_result1;
    logic [3:0]    req_finished1;
    logic [31:0]   dp_instruction1;
    logic [0:0]    dp_start1;
    logic [31:0]   dp_result1;
    logic [0:0]    dp_finished1;
    logic [0:0]    active_count1;

    int checks = 0;
    int errors = 0;

    datapath_dispatcher #(.PORTS(4), .UNITS(2), .INSTR_W(32), .RESULT_W(32)) dut0 (
        .clock           (clock),
        .resetn          (resetn),
        .req_instruction (req_instruction0),
        .req_start       (req_start0),
        .req_result      (req_result0),
        .req_finished    (req_finished0),
        .dp_instruction  (dp_instruction0),
        .dp_start        (dp_start0),
        .dp_result       (dp_result0),
        .dp_finished     (dp_finished0),
        .active_count    (active_count0)
    );

    datapath_dispatcher #(.PORTS(4), .UNITS(1), .INSTR_W(32), .RESULT_W(32)) dut1 (
        .clock           (clock),
        .resetn          (resetn),
        .req_instruction (req_instruction1),
        .req_start       (req_start1),
        .req_result      (req_result1),
        .req_finished    (req_finished1),
        .dp_instruction  (dp_instruction1),
        .dp_start        (dp_start1),
        .dp_result       (dp_result1),
        .dp_finished     (dp_finished1),
        .active_count    (active_count1)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Directed stimulus and checks.
    initial begin
        int ep;
        req_instruction0 = '0; req_start0 = '0; dp_result0 = '0; dp_finished0 = '0;
        req_instruction1 = '0; req_start1 = '0; dp_result1 = '0; dp_finished1 = '0;

        // Reset values
        resetn = 1'b0;
        tick(); tick();
        check("rst_fin",    128'(req_finished0),  128'h0F);
        check("rst_res",    req_result0,          128'h0);
        check("rst_start",  128'(dp_start0),      128'h0);
        check("rst_active", 128'(active_count0),  128'h0);
        check("rst_dpins",  128'(dp_instruction0), 128'h0);
        resetn = 1'b1;

        // Single op on port 2
        req_instruction0[2*32 +: 32] = 32'hA5;
        req_start0 = 4'b0100;
        tick();                                   // edge N
        req_start0 = 4'b0000;
        check("t2_fin_low",  128'(req_finished0), 128'h0B);
        check("t2_no_start", 128'(dp_start0),     128'h0);
        tick();                                   // N+1
        check("t2_start",   128'(dp_start0),             128'h1);
        check("t2_instr",   128'(dp_instruction0[31:0]), 128'hA5);
        check("t2_active",  128'(active_count0),         128'h1);
        tick();                                   // N+2
        check("t2_start_pulse", 128'(dp_start0), 128'h0);
        dp_finished0 = 2'b01; dp_result0[31:0] = 32'h1234;
        tick();                                   // N+3
        dp_finished0 = 2'b00;
        check("t2_fin",     128'(req_finished0), 128'h0F);
        check("t2_res",     req_result0,         {32'h0, 32'h1234, 64'h0});
        check("t2_idle",    128'(active_count0), 128'h0);

        // Contention: all four ports, two units
        resetn = 1'b0; tick(); resetn = 1'b1;
        for (int p = 0; p < 4; p++) req_instruction0[p*32 +: 32] = 32'h1000 + p;
        req_start0 = 4'b1111;
        tick();                                   // N
        req_start0 = 4'b0000;
        tick();                                   // N+1
        check("t3_start_u0", 128'(dp_start0),             128'h1);
        check("t3_instr_u0", 128'(dp_instruction0[31:0]), 128'h1000);
        tick();                                   // N+2
        check("t3_start_u1", 128'(dp_start0),              128'h2);
        check("t3_instr_u1", 128'(dp_instruction0[63:32]), 128'h1001);
        check("t3_active2",  128'(active_count0),          128'h2);
        check("t3_fin_none", 128'(req_finished0),          128'h0);
        dp_finished0 = 2'b01; dp_result0[31:0] = 32'h2000;
        tick();                                   // N+3: unit0 retires
        dp_finished0 = 2'b00;
        check("t3_fin_p0",  128'(req_finished0),     128'h1);
        check("t3_res_p0",  128'(req_result0[31:0]), 128'h2000);
        check("t3_active1", 128'(active_count0),     128'h1);
        tick();                                   // N+4: port2 onto unit0
        check("t3_regrant",  128'(dp_start0),              128'h1);
        check("t3_instr_p2", 128'(dp_instruction0[31:0]),  128'h1002);
        check("t3_hold_u1",  128'(dp_instruction0[63:32]), 128'h1001);
        check("t3_active2b", 128'(active_count0),          128'h2);

        // Reset mid-op with dp_finished held high
        dp_finished0 = 2'b11; dp_result0 = {32'hFFFF, 32'hEEEE};
        resetn = 1'b0;
        tick(); tick();
        check("t6_rst_fin", 128'(req_finished0), 128'h0F);
        check("t6_rst_res", req_result0,         128'h0);
        resetn = 1'b1;
        tick(); tick();
        check("t6_post_fin",    128'(req_finished0), 128'h0F);
        check("t6_post_res",    req_result0,         128'h0);
        check("t6_post_active", 128'(active_count0), 128'h0);
        check("t6_post_start",  128'(dp_start0),     128'h0);
        dp_finished0 = 2'b00; dp_result0 = '0;

        // Out-of-order completion
        req_instruction0[31:0] = 32'hC0; req_instruction0[63:32] = 32'hC1;
        req_start0 = 4'b0011;
        tick();                                   // N
        req_start0 = 4'b0000;
        tick(); tick();                           // N+1, N+2
        check("t5_instrs", 128'(dp_instruction0), {64'h0, 32'hC1, 32'hC0});
        tick();                                   // N+3: both busy
        dp_finished0 = 2'b10; dp_result0 = {32'hBEEF, 32'h0};
        tick();
        dp_finished0 = 2'b00;
        check("t5_fin_p1", 128'(req_finished0),      128'h0E);
        check("t5_res_p1", 128'(req_result0[63:32]), 128'hBEEF);
        check("t5_res_p0", 128'(req_result0[31:0]),  128'h0);
        dp_finished0 = 2'b01; dp_result0 = {32'h5555, 32'hCAFE};
        tick();
        dp_finished0 = 2'b00;
        check("t5_fin_all", 128'(req_finished0), 128'h0F);
        check("t5_res_all", req_result0,         {64'h0, 32'hBEEF, 32'hCAFE});

        // Fairness with a single unit: grants alternate 0,3,0,3
        resetn = 1'b0; tick(); resetn = 1'b1;
        req_instruction1[0*32 +: 32] = 32'h0A;
        req_instruction1[3*32 +: 32] = 32'h3A;
        req_start1 = 4'b1001;
        tick();
        req_start1 = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            ep = (k % 2 == 0) ? 0 : 3;
            tick();                               // grant edge
            req_start1 = 4'b0000;
            check("t4_start", 128'(dp_start1), 128'h1);
            check("t4_instr", 128'(dp_instruction1), (ep == 0) ? 128'h0A : 128'h3A);
            tick();
            dp_finished1 = 1'b1; dp_result1 = 32'h100 + k;
            tick();
            dp_finished1 = 1'b0;
            check("t4_fin", 128'(req_finished1[ep]), 128'h1);
            check("t4_res", 128'(req_result1[ep*32 +: 32]), 128'(32'h100 + k));
            req_start1 = (ep == 0) ? 4'b0001 : 4'b1000;
        end
        tick();
        req_start1 = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
